// File: rtl/debouncer_multi.sv
// Multi-channel debouncer: per-channel 2-flop synchroniser, stability counter and FSM,
// with registered debounced level and one-cycle p_edge/n_edge/any_edge strobes.
module debouncer_multi #(
  parameter int CHANNELS        = 4,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter bit EARLY_MODE      = 1'b0,
  parameter bit RESET_LEVEL     = 1'b0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] noisy,
  output logic [CHANNELS-1:0] debounced,
  output logic [CHANNELS-1:0] p_edge,
  output logic [CHANNELS-1:0] n_edge,
  output logic [CHANNELS-1:0] any_edge
);

  localparam int CW = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_PRE  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  // PEND1/PEND0 are WAIT states in delayed mode and LOCK states in early mode.
  typedef enum logic [1:0] {
    STABLE0 = 2'd0,
    PEND1   = 2'd1,
    STABLE1 = 2'd2,
    PEND0   = 2'd3
  } state_t;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic          sync1, sync2;
    state_t        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic          deb, deb_nx;
    logic          pe, pe_nx;
    logic          ne, ne_nx;
    logic          ae;

    always_ff @(posedge clk) begin
      if (reset) begin
        sync1 <= RESET_LEVEL;
        sync2 <= RESET_LEVEL;
        state <= RESET_LEVEL ? STABLE1 : STABLE0;
        cnt   <= '0;
        deb   <= RESET_LEVEL;
        pe    <= 1'b0;
        ne    <= 1'b0;
        ae    <= 1'b0;
      end else begin
        sync1 <= noisy[i];
        sync2 <= sync1;
        state <= state_nx;
        cnt   <= cnt_nx;
        deb   <= deb_nx;
        pe    <= pe_nx;
        ne    <= ne_nx;
        ae    <= pe_nx | ne_nx;
      end
    end

    always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      deb_nx   = deb;
      pe_nx    = 1'b0;
      ne_nx    = 1'b0;
      case (state)
        STABLE0: begin
          if (sync2) begin
            if (EARLY_MODE) begin
              state_nx = PEND1;
              cnt_nx   = CNT_ONE;
              deb_nx   = 1'b1;
              pe_nx    = 1'b1;
            end else if (DEBOUNCE_CYCLES <= 1) begin
              state_nx = STABLE1;
              deb_nx   = 1'b1;
              pe_nx    = 1'b1;
            end else begin
              state_nx = PEND1;
              cnt_nx   = CNT_ONE;
            end
          end
        end
        PEND1: begin
          if (EARLY_MODE) begin
            // Lockout holds for D+1 cycles in total before the opposite change is allowed.
            if (cnt == CNT_LAST) begin
              state_nx = STABLE1;
              cnt_nx   = '0;
            end else begin
              cnt_nx = cnt + CNT_ONE;
            end
          end else if (!sync2) begin
            state_nx = STABLE0;
            cnt_nx   = '0;
          end else if (cnt == CNT_PRE) begin
            state_nx = STABLE1;
            cnt_nx   = '0;
            deb_nx   = 1'b1;
            pe_nx    = 1'b1;
          end else begin
            cnt_nx = cnt + CNT_ONE;
          end
        end
        STABLE1: begin
          if (!sync2) begin
            if (EARLY_MODE) begin
              state_nx = PEND0;
              cnt_nx   = CNT_ONE;
              deb_nx   = 1'b0;
              ne_nx    = 1'b1;
            end else if (DEBOUNCE_CYCLES <= 1) begin
              state_nx = STABLE0;
              deb_nx   = 1'b0;
              ne_nx    = 1'b1;
            end else begin
              state_nx = PEND0;
              cnt_nx   = CNT_ONE;
            end
          end
        end
        PEND0: begin
          if (EARLY_MODE) begin
            if (cnt == CNT_LAST) begin
              state_nx = STABLE0;
              cnt_nx   = '0;
            end else begin
              cnt_nx = cnt + CNT_ONE;
            end
          end else if (sync2) begin
            state_nx = STABLE1;
            cnt_nx   = '0;
          end else if (cnt == CNT_PRE) begin
            state_nx = STABLE0;
            cnt_nx   = '0;
            deb_nx   = 1'b0;
            ne_nx    = 1'b1;
          end else begin
            cnt_nx = cnt + CNT_ONE;
          end
        end
        default: begin
          state_nx = STABLE0;
          cnt_nx   = '0;
        end
      endcase
    end

    assign debounced[i] = deb;
    assign p_edge[i]    = pe;
    assign n_edge[i]    = ne;
    assign any_edge[i]  = ae;
  end

endmodule

// File: tb/tb_debouncer_multi.sv
// Directed bench for debouncer_multi: delayed mode, early mode and RESET_LEVEL=1 instances, D=4.
module tb_debouncer_multi;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] noisy_d, deb_d, pe_d, ne_d, ae_d;
  logic [3:0] noisy_e, deb_e, pe_e, ne_e, ae_e;
  logic [3:0] noisy_r, deb_r, pe_r, ne_r, ae_r;
  logic [15:0] exp_v;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  debouncer_multi #(.CHANNELS(4), .DEBOUNCE_CYCLES(4), .EARLY_MODE(1'b0), .RESET_LEVEL(1'b0)) u_del (
    .clk(clk), .reset(reset), .noisy(noisy_d),
    .debounced(deb_d), .p_edge(pe_d), .n_edge(ne_d), .any_edge(ae_d));

  debouncer_multi #(.CHANNELS(4), .DEBOUNCE_CYCLES(4), .EARLY_MODE(1'b1), .RESET_LEVEL(1'b0)) u_early (
    .clk(clk), .reset(reset), .noisy(noisy_e),
    .debounced(deb_e), .p_edge(pe_e), .n_edge(ne_e), .any_edge(ae_e));

  debouncer_multi #(.CHANNELS(4), .DEBOUNCE_CYCLES(4), .EARLY_MODE(1'b0), .RESET_LEVEL(1'b1)) u_rl (
    .clk(clk), .reset(reset), .noisy(noisy_r),
    .debounced(deb_r), .p_edge(pe_r), .n_edge(ne_r), .any_edge(ae_r));

  // Expected vectors are {debounced, p_edge, n_edge, any_edge}.
  task automatic test_reset();
    reset = 1'b1;
    noisy_d = 4'h0;
    noisy_e = 4'h0;
    noisy_r = 4'hF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({deb_d, pe_d, ne_d, ae_d} !== 16'h0000) begin
      failures++;
      $display("FAIL reset_del got=%h exp=%h", {deb_d, pe_d, ne_d, ae_d}, 16'h0000);
    end
    checks++;
    if ({deb_e, pe_e, ne_e, ae_e} !== 16'h0000) begin
      failures++;
      $display("FAIL reset_early got=%h exp=%h", {deb_e, pe_e, ne_e, ae_e}, 16'h0000);
    end
    checks++;
    if ({deb_r, pe_r, ne_r, ae_r} !== 16'hF000) begin
      failures++;
      $display("FAIL reset_rl1 got=%h exp=%h", {deb_r, pe_r, ne_r, ae_r}, 16'hF000);
    end
    reset = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk);
      @(negedge clk);
      checks++;
      if ({deb_r, pe_r, ne_r, ae_r} !== 16'hF000) begin
        failures++;
        $display("FAIL release_rl1 k=%0d got=%h exp=%h", k, {deb_r, pe_r, ne_r, ae_r}, 16'hF000);
      end
    end
  endtask

  task automatic test_delayed_rise();
    noisy_d[0] = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      @(negedge clk);
      exp_v = {(k >= 6) ? 4'h1 : 4'h0, (k == 6) ? 4'h1 : 4'h0, 4'h0, (k == 6) ? 4'h1 : 4'h0};
      checks++;
      if ({deb_d, pe_d, ne_d, ae_d} !== exp_v) begin
        failures++;
        $display("FAIL delayed_rise k=%0d got=%h exp=%h", k, {deb_d, pe_d, ne_d, ae_d}, exp_v);
      end
    end
    noisy_d[0] = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      @(negedge clk);
      exp_v = {(k >= 6) ? 4'h0 : 4'h1, 4'h0, (k == 6) ? 4'h1 : 4'h0, (k == 6) ? 4'h1 : 4'h0};
      checks++;
      if ({deb_d, pe_d, ne_d, ae_d} !== exp_v) begin
        failures++;
        $display("FAIL delayed_fall k=%0d got=%h exp=%h", k, {deb_d, pe_d, ne_d, ae_d}, exp_v);
      end
    end
  endtask

  task automatic test_short_pulse();
    noisy_d[1] = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == 3) noisy_d[1] = 1'b0;
      checks++;
      if ({deb_d, pe_d, ne_d, ae_d} !== 16'h0000) begin
        failures++;
        $display("FAIL short3 k=%0d got=%h exp=%h", k, {deb_d, pe_d, ne_d, ae_d}, 16'h0000);
      end
    end
    noisy_d[1] = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == 4) noisy_d[1] = 1'b0;
      exp_v = {(k >= 6 && k <= 9) ? 4'h2 : 4'h0, (k == 6) ? 4'h2 : 4'h0,
               (k == 10) ? 4'h2 : 4'h0, (k == 6 || k == 10) ? 4'h2 : 4'h0};
      checks++;
      if ({deb_d, pe_d, ne_d, ae_d} !== exp_v) begin
        failures++;
        $display("FAIL hold4 k=%0d got=%h exp=%h", k, {deb_d, pe_d, ne_d, ae_d}, exp_v);
      end
    end
  endtask

  task automatic test_early();
    noisy_e[2] = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == 1) noisy_e[2] = 1'b0;
      exp_v = {(k >= 3 && k <= 7) ? 4'h4 : 4'h0, (k == 3) ? 4'h4 : 4'h0,
               (k == 8) ? 4'h4 : 4'h0, (k == 3 || k == 8) ? 4'h4 : 4'h0};
      checks++;
      if ({deb_e, pe_e, ne_e, ae_e} !== exp_v) begin
        failures++;
        $display("FAIL early_pulse k=%0d got=%h exp=%h", k, {deb_e, pe_e, ne_e, ae_e}, exp_v);
      end
    end
  endtask

  task automatic test_early_bounce();
    logic [5:0] pattern;
    pattern = 6'b100101;  // noisy_e[3] at edges 1..6 read LSB first: 1,0,1,0,0,1
    noisy_e[3] = pattern[0];
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k < 6) noisy_e[3] = pattern[k];
      exp_v = {(k >= 3) ? 4'h8 : 4'h0, (k == 3) ? 4'h8 : 4'h0, 4'h0, (k == 3) ? 4'h8 : 4'h0};
      checks++;
      if ({deb_e, pe_e, ne_e, ae_e} !== exp_v) begin
        failures++;
        $display("FAIL early_bounce k=%0d got=%h exp=%h", k, {deb_e, pe_e, ne_e, ae_e}, exp_v);
      end
    end
    noisy_e[3] = 1'b0;
    repeat (14) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({deb_e, pe_e, ne_e, ae_e} !== 16'h0000) begin
      failures++;
      $display("FAIL early_settle got=%h exp=%h", {deb_e, pe_e, ne_e, ae_e}, 16'h0000);
    end
  endtask

  task automatic test_reset_mid_wait();
    noisy_d[2] = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if ({deb_d, pe_d, ne_d, ae_d} !== 16'h0000) begin
      failures++;
      $display("FAIL reset_mid_wait got=%h exp=%h", {deb_d, pe_d, ne_d, ae_d}, 16'h0000);
    end
    for (int k = 6; k <= 14; k++) begin
      @(posedge clk);
      @(negedge clk);
      exp_v = {(k >= 11) ? 4'h4 : 4'h0, (k == 11) ? 4'h4 : 4'h0, 4'h0, (k == 11) ? 4'h4 : 4'h0};
      checks++;
      if ({deb_d, pe_d, ne_d, ae_d} !== exp_v) begin
        failures++;
        $display("FAIL restart k=%0d got=%h exp=%h", k, {deb_d, pe_d, ne_d, ae_d}, exp_v);
      end
    end
  endtask

  task automatic test_back_to_back_rl1();
    noisy_r = 4'h0;
    for (int k = 1; k <= 9; k++) begin
      @(posedge clk);
      @(negedge clk);
      exp_v = {(k >= 6) ? 4'h0 : 4'hF, 4'h0, (k == 6) ? 4'hF : 4'h0, (k == 6) ? 4'hF : 4'h0};
      checks++;
      if ({deb_r, pe_r, ne_r, ae_r} !== exp_v) begin
        failures++;
        $display("FAIL rl1_simul k=%0d got=%h exp=%h", k, {deb_r, pe_r, ne_r, ae_r}, exp_v);
      end
    end
  endtask

  initial begin
    test_reset();
    test_delayed_rise();
    test_short_pulse();
    test_early();
    test_early_bounce();
    test_back_to_back_rl1();
    test_reset_mid_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
